// File: rtl/uart_port_ctrl.sv
// Host command sequencer: parses UART bytes into 32-bit port writes, and returns
// port reads to the host as four tx bytes, MSB first.
module uart_port_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned ERRCNT_W       = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rxready,
  input  logic [7:0]          rxdata,
  input  logic                txready,
  output logic                txen,
  output logic [7:0]          txdata,
  output logic [3:0]          port_addr,
  output logic [31:0]         port_wdata,
  output logic                port_we,
  input  logic [31:0]         port_rdata,
  output logic                busy,
  output logic [ERRCNT_W-1:0] cmd_err
);

  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_COMMIT, RD_ADDR, RD_LATCH, TX_SEND, TX_WAIT
  } state_t;

  state_t              state, state_d;
  logic                rx_q;
  logic [2:0]          bytecnt, bytecnt_d;
  logic [TCW-1:0]      tcnt, tcnt_d;
  logic [31:0]         sr, sr_d;
  logic [31:0]         txbuf, txbuf_d;
  logic                tx_low, tx_low_d;
  logic                txen_d, port_we_d, busy_d, err_inc;
  logic [7:0]          txdata_d;
  logic [3:0]          port_addr_d;
  logic [31:0]         port_wdata_d;
  logic [ERRCNT_W-1:0] cmd_err_d;
  logic                ev;

  // One byte event per rising edge of rxready, whatever its pulse width.
  assign ev = rxready & ~rx_q;

  always_comb begin
    state_d      = state;
    bytecnt_d    = bytecnt;
    tcnt_d       = tcnt;
    sr_d         = sr;
    txbuf_d      = txbuf;
    tx_low_d     = tx_low;
    txdata_d     = txdata;
    port_addr_d  = port_addr;
    port_wdata_d = port_wdata;
    cmd_err_d    = cmd_err;
    txen_d       = 1'b0;
    port_we_d    = 1'b0;
    err_inc      = 1'b0;

    case (state)
      IDLE: begin
        if (ev) begin
          if (rxdata[7:4] == 4'b0010) begin
            port_addr_d = rxdata[3:0];
            bytecnt_d   = 3'd0;
            tcnt_d      = '0;
            state_d     = WR_DATA;
          end else if (rxdata[7:4] == 4'b0011) begin
            port_addr_d = rxdata[3:0];
            state_d     = RD_ADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (ev) begin
          sr_d      = {sr[23:0], rxdata};
          bytecnt_d = bytecnt + 3'd1;
          tcnt_d    = '0;
          if (bytecnt == 3'd3) state_d = WR_COMMIT;
        end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end else begin
          tcnt_d = tcnt + TCW'(1);
        end
      end
      WR_COMMIT: begin
        port_wdata_d = sr;
        port_we_d    = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR:  state_d = RD_LATCH;
      RD_LATCH: begin
        // Single snapshot so all four reply bytes are coherent.
        txbuf_d   = port_rdata;
        bytecnt_d = 3'd0;
        state_d   = TX_SEND;
      end
      TX_SEND: begin
        if (txready) begin
          txen_d    = 1'b1;
          txdata_d  = txbuf[31:24];
          txbuf_d   = {txbuf[23:0], 8'h00};
          bytecnt_d = bytecnt + 3'd1;
          tx_low_d  = 1'b0;
          state_d   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Require a full busy period of the transmitter before the next byte.
        if (!txready) begin
          tx_low_d = 1'b1;
        end else if (tx_low) begin
          state_d = (bytecnt == 3'd4) ? IDLE : TX_SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (cmd_err != '1)) cmd_err_d = cmd_err + ERRCNT_W'(1);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rx_q       <= 1'b0;
      bytecnt    <= 3'd0;
      tcnt       <= '0;
      sr         <= 32'd0;
      txbuf      <= 32'd0;
      tx_low     <= 1'b0;
      txen       <= 1'b0;
      txdata     <= 8'd0;
      port_addr  <= 4'd0;
      port_wdata <= 32'd0;
      port_we    <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= '0;
    end else begin
      state      <= state_d;
      rx_q       <= rxready;
      bytecnt    <= bytecnt_d;
      tcnt       <= tcnt_d;
      sr         <= sr_d;
      txbuf      <= txbuf_d;
      tx_low     <= tx_low_d;
      txen       <= txen_d;
      txdata     <= txdata_d;
      port_addr  <= port_addr_d;
      port_wdata <= port_wdata_d;
      port_we    <= port_we_d;
      busy       <= busy_d;
      cmd_err    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Directed bench for uart_port_ctrl: host writes, reads, bad opcodes, timeout,
// reset mid-reply, and error-counter saturation on a narrow second instance.
module tb_uart_port_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxready = 1'b0;
  logic [7:0]  rxdata = 8'd0;
  logic        txready = 1'b1;
  logic        txen;
  logic [7:0]  txdata;
  logic [3:0]  port_addr;
  logic [31:0] port_wdata;
  logic        port_we;
  logic [31:0] port_rdata;
  logic        busy;
  logic [7:0]  cmd_err;

  logic        rxready2 = 1'b0;
  logic [7:0]  rxdata2 = 8'd0;
  logic        txready2 = 1'b1;
  logic        txen2;
  logic [7:0]  txdata2;
  logic [3:0]  port_addr2;
  logic [31:0] port_wdata2;
  logic        port_we2;
  logic [31:0] port_rdata2 = 32'd0;
  logic        busy2;
  logic [1:0]  cmd_err2;

  logic [31:0] regs [16];
  assign port_rdata = regs[port_addr];

  int tests = 0;
  int fails = 0;

  uart_port_ctrl #(.TIMEOUT_CYCLES(1000), .ERRCNT_W(8)) dut (
    .clock(clock), .reset(reset), .rxready(rxready), .rxdata(rxdata),
    .txready(txready), .txen(txen), .txdata(txdata), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_we(port_we), .port_rdata(port_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  uart_port_ctrl #(.TIMEOUT_CYCLES(1000), .ERRCNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .rxready(rxready2), .rxdata(rxdata2),
    .txready(txready2), .txen(txen2), .txdata(txdata2), .port_addr(port_addr2),
    .port_wdata(port_wdata2), .port_we(port_we2), .port_rdata(port_rdata2),
    .busy(busy2), .cmd_err(cmd_err2)
  );

  always #5 clock = ~clock;

  // UART transmitter model: drops txready for a few cycles after each load.
  int        txn = 0;
  int        txen_wide = 0;
  logic [7:0] txlog [32];
  logic      txen_prev = 1'b0;
  int        tx_cnt = 0;
  always @(posedge clock) begin
    txen_prev <= txen;
    if (txen) begin
      if (txen_prev) txen_wide <= txen_wide + 1;
      if (txn < 32) txlog[txn] <= txdata;
      txn     <= txn + 1;
      txready <= 1'b0;
      tx_cnt  <= 4;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) txready <= 1'b1;
    end
  end

  // Port-file write monitor.
  int          we_count = 0;
  logic [3:0]  we_addr = 4'd0;
  logic [31:0] we_data = 32'd0;
  always @(posedge clock) begin
    if (port_we) begin
      we_count <= we_count + 1;
      we_addr  <= port_addr;
      we_data  <= port_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit to2);
    @(negedge clock);
    if (to2) begin rxdata2 = b; rxready2 = 1'b1; end
    else begin rxdata = b; rxready = 1'b1; end
    repeat (2) @(negedge clock);
    rxready  = 1'b0;
    rxready2 = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_write(input logic [3:0] a, input logic [31:0] d);
    send_byte({4'b0010, a}, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clock); n++; end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_txn(input string tag, input int target);
    int n = 0;
    while (txn < target && n < 5000) begin @(negedge clock); n++; end
    check(tag, (txn >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int we0;
    int base;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_txen", {31'd0, txen}, 32'd0);
    check("rst_we", {31'd0, port_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {24'd0, cmd_err}, 32'd0);
    check("rst_wdata", port_wdata, 32'd0);
    check("rst_addr", {28'd0, port_addr}, 32'd0);

    // Write port 2 with 0x0000000E
    we0 = we_count;
    send_write(4'd2, 32'h0000000E);
    wait_idle("t1_idle");
    repeat (3) @(negedge clock);
    check("t1_we_count", 32'(we_count - we0), 32'd1);
    check("t1_we_addr", {28'd0, we_addr}, 32'd2);
    check("t1_we_data", we_data, 32'h0000000E);
    check("t1_err", {24'd0, cmd_err}, 32'd0);

    // Write port 3 with 0xFFFFFFB1, value held afterwards
    send_write(4'd3, 32'hFFFFFFB1);
    wait_idle("t2_idle");
    repeat (3) @(negedge clock);
    check("t2_we_count", 32'(we_count - we0), 32'd2);
    check("t2_we_addr", {28'd0, we_addr}, 32'd3);
    check("t2_wdata", port_wdata, 32'hFFFFFFB1);
    repeat (20) @(negedge clock);
    check("t2_wdata_held", port_wdata, 32'hFFFFFFB1);
    check("t2_we_low", {31'd0, port_we}, 32'd0);

    // Read port 1; port data changes after the first reply byte
    regs[1] = 32'h00003A66;
    base = txn;
    send_byte(8'h31, 1'b0);
    wait_txn("t3_first", base + 1);
    regs[1] = 32'hDEADBEEF;
    wait_idle("t3_idle");
    check("t3_count", 32'(txn - base), 32'd4);
    check("t3_b0", {24'd0, txlog[base]}, 32'h00);
    check("t3_b1", {24'd0, txlog[base+1]}, 32'h00);
    check("t3_b2", {24'd0, txlog[base+2]}, 32'h3A);
    check("t3_b3", {24'd0, txlog[base+3]}, 32'h66);
    check("t3_txen_1cyc", 32'(txen_wide), 32'd0);
    check("t3_no_we", 32'(we_count - we0), 32'd2);

    // Bad opcodes, then a valid write
    base = txn;
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA0, 1'b0);
    repeat (5) @(negedge clock);
    check("t4_err", {24'd0, cmd_err}, 32'd2);
    check("t4_no_we", 32'(we_count - we0), 32'd2);
    check("t4_no_tx", 32'(txn - base), 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    send_write(4'd5, 32'h11223344);
    wait_idle("t4_idle");
    repeat (3) @(negedge clock);
    check("t4_wdata", port_wdata, 32'h11223344);
    check("t4_we_addr", {28'd0, we_addr}, 32'd5);

    // Timeout mid-write
    we0 = we_count;
    send_byte(8'h24, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (500) @(negedge clock);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    repeat (700) @(negedge clock);
    check("t5_abort_idle", {31'd0, busy}, 32'd0);
    check("t5_no_we", 32'(we_count - we0), 32'd0);
    check("t5_err", {24'd0, cmd_err}, 32'd3);
    send_write(4'd4, 32'h00000001);
    wait_idle("t5b_idle");
    repeat (3) @(negedge clock);
    check("t5_we_count", 32'(we_count - we0), 32'd1);
    check("t5_wdata", port_wdata, 32'h00000001);
    check("t5_we_addr", {28'd0, we_addr}, 32'd4);

    // Reset after the second reply byte
    regs[1] = 32'hA1B2C3D4;
    base = txn;
    send_byte(8'h31, 1'b0);
    wait_txn("t6_two", base + 2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_txen", {31'd0, txen}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_txdata", {24'd0, txdata}, 32'd0);
    check("t6_wdata", port_wdata, 32'd0);
    check("t6_addr", {28'd0, port_addr}, 32'd0);
    check("t6_err", {24'd0, cmd_err}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("t6_truncated", 32'(txn - base), 32'd2);
    regs[3] = 32'h0BADF00D;
    base = txn;
    send_byte(8'h33, 1'b0);
    wait_txn("t6_reply", base + 4);
    wait_idle("t6_idle");
    check("t6_count", 32'(txn - base), 32'd4);
    check("t6_r0", {24'd0, txlog[base]}, 32'h0B);
    check("t6_r1", {24'd0, txlog[base+1]}, 32'hAD);
    check("t6_r2", {24'd0, txlog[base+2]}, 32'hF0);
    check("t6_r3", {24'd0, txlog[base+3]}, 32'h0D);

    // Saturating error counter on the 2-bit instance
    send_byte(8'hF0, 1'b1);
    send_byte(8'h10, 1'b1);
    check("sat_two", {30'd0, cmd_err2}, 32'd2);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h45, 1'b1);
    check("sat_three", {30'd0, cmd_err2}, 32'd3);
    check("sat_busy", {31'd0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
